// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Detects rising/falling edges on NUM_CH synchronous lines, latches enabled
// edges as pending events (one slot per edge type per channel) and hands them
// one at a time to a single consumer through a round-robin arbiter and a
// valid/ready port. All outputs come straight from flops.
module edge_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] a_i,
  input  logic [NUM_CH-1:0] rise_en_i,
  input  logic [NUM_CH-1:0] fall_en_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [CH_W-1:0]   evt_ch_o,
  output logic              evt_rise_o,
  output logic [NUM_CH-1:0] ovf_o,
  input  logic              ovf_clr_i,
  output logic              busy_o
);

  // Slot 2i holds a rising edge of channel i, slot 2i+1 a falling edge.
  localparam int NS = 2 * NUM_CH;
  localparam int SW = $clog2(NS);
  localparam int IW = SW + 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [NUM_CH-1:0]   a_prev_r;
  logic [NS-1:0]       pend_r, pend_nxt_s;
  logic [SW-1:0]       ptr_r, ptr_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic [CH_W-1:0]     ch_r, ch_nxt_s;
  logic                rise_r, rise_nxt_s;
  logic [NUM_CH-1:0]   ovf_r, ovf_nxt_s, ovf_set_s;
  logic                busy_r, busy_nxt_s;

  logic [NUM_CH-1:0]   rise_s, fall_s;
  logic [NS-1:0]       set_s, grant_s;
  logic                any_pend_s, found_s, do_grant_s;
  logic [SW-1:0]       gnt_idx_s;
  logic [IW-1:0]       idx_s;

  // Edge detection and mapping of enabled edges onto their request slots.
  always_comb begin
    rise_s = ~a_prev_r & a_i;
    fall_s = a_prev_r & ~a_i;
    set_s  = {NS{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      set_s[2*i]   = rise_s[i] & rise_en_i[i];
      set_s[2*i+1] = fall_s[i] & fall_en_i[i];
    end
  end

  // Round-robin search: first pending slot at or after ptr, wrapping.
  always_comb begin
    any_pend_s = |pend_r;
    found_s    = 1'b0;
    gnt_idx_s  = {SW{1'b0}};
    idx_s      = {IW{1'b0}};
    for (int k = 0; k < NS; k++) begin
      idx_s = {1'b0, ptr_r} + IW'(k);
      idx_s = (idx_s >= IW'(NS)) ? (idx_s - IW'(NS)) : idx_s;
      gnt_idx_s = (!found_s && pend_r[idx_s[SW-1:0]]) ? idx_s[SW-1:0] : gnt_idx_s;
      found_s   = found_s | pend_r[idx_s[SW-1:0]];
    end
  end

  // Handshake FSM: decides when a slot is granted and what is presented.
  always_comb begin
    state_nxt_s = state_r;
    valid_nxt_s = valid_r;
    do_grant_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_pend_s) begin
          do_grant_s  = 1'b1;
          valid_nxt_s = 1'b1;
          state_nxt_s = PRESENT;
        end else begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      PRESENT: begin
        if (valid_r && evt_ready_i) begin
          if (any_pend_s) begin
            do_grant_s  = 1'b1;
            valid_nxt_s = 1'b1;
            state_nxt_s = PRESENT;
          end else begin
            valid_nxt_s = 1'b0;
            state_nxt_s = IDLE;
          end
        end else begin
          valid_nxt_s = valid_r;
          state_nxt_s = PRESENT;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Event payload, pointer advance, slot bookkeeping and sticky overflow.
  always_comb begin
    if (do_grant_s) begin
      ch_nxt_s   = CH_W'(gnt_idx_s >> 1);
      rise_nxt_s = ~gnt_idx_s[0];
      grant_s    = {{(NS-1){1'b0}}, 1'b1} << gnt_idx_s;
      ptr_nxt_s  = (gnt_idx_s == SW'(NS - 1)) ? {SW{1'b0}} : (gnt_idx_s + {{(SW-1){1'b0}}, 1'b1});
    end else begin
      ch_nxt_s   = ch_r;
      rise_nxt_s = rise_r;
      grant_s    = {NS{1'b0}};
      ptr_nxt_s  = ptr_r;
    end
    // A new edge on a slot being granted this cycle re-arms it (set wins).
    pend_nxt_s = (pend_r & ~grant_s) | set_s;
    ovf_set_s  = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ovf_set_s[i] = (set_s[2*i]   & pend_r[2*i]   & ~grant_s[2*i]) |
                     (set_s[2*i+1] & pend_r[2*i+1] & ~grant_s[2*i+1]);
    end
    ovf_nxt_s  = (ovf_r & ~{NUM_CH{ovf_clr_i}}) | ovf_set_s;
    busy_nxt_s = valid_nxt_s | (|pend_nxt_s);
  end

  // State and output registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      a_prev_r <= {NUM_CH{1'b0}};
      pend_r   <= {NS{1'b0}};
      ptr_r    <= {SW{1'b0}};
      valid_r  <= 1'b0;
      ch_r     <= {CH_W{1'b0}};
      rise_r   <= 1'b0;
      ovf_r    <= {NUM_CH{1'b0}};
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      a_prev_r <= a_i;
      pend_r   <= pend_nxt_s;
      ptr_r    <= ptr_nxt_s;
      valid_r  <= valid_nxt_s;
      ch_r     <= ch_nxt_s;
      rise_r   <= rise_nxt_s;
      ovf_r    <= ovf_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign evt_valid_o = valid_r;
  assign evt_ch_o    = ch_r;
  assign evt_rise_o  = rise_r;
  assign ovf_o       = ovf_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter (NUM_CH = 4). Stimulus pushes the
// hand-derived event sequence; a negedge monitor pops one entry per handshake.
module tb_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] a_i, rise_en, fall_en, ovf;
  logic         evt_valid, evt_ready, evt_rise, ovf_clr, busy;
  logic [1:0]   evt_ch;

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;

  edge_event_arbiter #(.NUM_CH(N)) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .rise_en_i(rise_en), .fall_en_i(fall_en),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready), .evt_ch_o(evt_ch),
    .evt_rise_o(evt_rise), .ovf_o(ovf), .ovf_clr_i(ovf_clr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] ch, input logic r);
    exp_q.push_back({ch, r});
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_evt: got ch %0d rise %0d, required no event", evt_ch, evt_rise);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("evt_ch_rise", {29'd0, evt_ch, evt_rise}, {29'd0, mon_exp});
      end
    end
  end

  initial begin
    reset = 1'b1; a_i = 4'b0000; rise_en = 4'b1111; fall_en = 4'b1111;
    evt_ready = 1'b1; ovf_clr = 1'b0;
    tick(2);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_ch", evt_ch, 2'd0);
    chk("rst_rise", evt_rise, 1'b0);
    chk("rst_ovf", ovf, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(2);

    // Single edge on ch 2: pending after one edge, valid after the second.
    a_i[2] = 1'b1; push(2'd2, 1'b1);
    tick(1);
    chk("lat_valid_early", evt_valid, 1'b0);
    chk("lat_busy", busy, 1'b1);
    tick(1);
    chk("lat_valid", evt_valid, 1'b1);
    chk("lat_ch", evt_ch, 2'd2);
    chk("lat_rise", evt_rise, 1'b1);
    tick(1);
    chk("single_done", evt_valid, 1'b0);
    a_i[2] = 1'b0; push(2'd2, 1'b0);
    tick(4);

    // ptr = 6: slots 0,2,6 pending -> ch 3, 0, 1 back-to-back.
    a_i = 4'b1011; push(2'd3, 1'b1); push(2'd0, 1'b1); push(2'd1, 1'b1);
    tick(2);
    chk("b2b_0", {evt_valid, evt_ch}, {1'b1, 2'd3});
    tick(1);
    chk("b2b_1", {evt_valid, evt_ch}, {1'b1, 2'd0});
    tick(1);
    chk("b2b_2", {evt_valid, evt_ch}, {1'b1, 2'd1});
    tick(1);
    chk("b2b_end", evt_valid, 1'b0);
    // ptr = 3: slots 1,3,7 -> ch1 fall, ch3 fall, ch0 fall.
    a_i = 4'b0000; push(2'd1, 1'b0); push(2'd3, 1'b0); push(2'd0, 1'b0);
    tick(5);
    // Put ptr at 7, discard the ch3 fall, then ch0 must win over ch3.
    a_i[3] = 1'b1; push(2'd3, 1'b1);
    tick(4);
    fall_en[3] = 1'b0; a_i[3] = 1'b0;
    tick(3);
    fall_en[3] = 1'b1;
    a_i = 4'b1001; push(2'd0, 1'b1); push(2'd3, 1'b1);
    tick(2);
    chk("wrap_first", evt_ch, 2'd0);
    tick(1);
    chk("wrap_second", evt_ch, 2'd3);
    tick(2);
    a_i = 4'b0000; push(2'd3, 1'b0); push(2'd0, 1'b0);
    tick(5);

    // Backpressure with ptr = 2: ch1 rise held, ch2 rise follows without a bubble.
    evt_ready = 1'b0;
    a_i[1] = 1'b1; push(2'd1, 1'b1); push(2'd2, 1'b1);
    tick(2);
    a_i[2] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_hold", {evt_valid, evt_ch, evt_rise}, {1'b1, 2'd1, 1'b1});
    end
    evt_ready = 1'b1;
    tick(1);
    chk("bp_next", {evt_valid, evt_ch, evt_rise}, {1'b1, 2'd2, 1'b1});
    tick(1);
    chk("bp_end", evt_valid, 1'b0);
    a_i = 4'b0000; push(2'd2, 1'b0); push(2'd1, 1'b0);
    tick(5);

    // Overflow on ch 3 while a ch0 event blocks the port.
    evt_ready = 1'b0;
    a_i[0] = 1'b1;
    tick(3);
    a_i[3] = 1'b1; tick(1);
    a_i[3] = 1'b0; tick(1);
    a_i[3] = 1'b1; tick(1);
    a_i[3] = 1'b0; tick(1);
    tick(1);
    chk("ovf_set", ovf, 4'b1000);
    ovf_clr = 1'b1; tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 4'b0000);
    push(2'd0, 1'b1); push(2'd3, 1'b1); push(2'd3, 1'b0);
    evt_ready = 1'b1;
    tick(5);
    a_i[0] = 1'b0; push(2'd0, 1'b0);
    tick(4);

    // Disabled fall on ch 1: only the rise is delivered.
    fall_en[1] = 1'b0;
    a_i[1] = 1'b1; push(2'd1, 1'b1);
    tick(4);
    a_i[1] = 1'b0;
    tick(3);
    chk("en_idle", {evt_valid, busy}, {1'b0, 1'b0});
    fall_en[1] = 1'b1;

    // Same-cycle grant and new edge on slot 4: stays pending, no overflow.
    fall_en[2] = 1'b0; evt_ready = 1'b0;
    a_i[3] = 1'b1; push(2'd3, 1'b1);
    tick(3);
    a_i[2] = 1'b1; tick(2);
    a_i[2] = 1'b0; tick(2);
    push(2'd2, 1'b1); push(2'd2, 1'b1);
    a_i[2] = 1'b1; evt_ready = 1'b1;
    tick(1);
    chk("setwin_1", {evt_valid, evt_ch}, {1'b1, 2'd2});
    tick(1);
    chk("setwin_2", {evt_valid, evt_ch}, {1'b1, 2'd2});
    tick(1);
    chk("setwin_end", evt_valid, 1'b0);
    chk("setwin_ovf", ovf, 4'b0000);
    a_i[3] = 1'b0; push(2'd3, 1'b0);
    tick(4);
    fall_en = 4'b1111;

    // Reset in the middle of a held event with two more pending.
    evt_ready = 1'b0;
    a_i = 4'b0011;
    tick(3);
    chk("pre_rst", {evt_valid, busy}, {1'b1, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid_busy", {evt_valid, busy}, {1'b0, 1'b0});
    chk("mid_rst_ch_rise", {evt_ch, evt_rise}, {2'd0, 1'b0});
    a_i = 4'b0001; evt_ready = 1'b1;
    tick(1);
    reset = 1'b0; push(2'd0, 1'b1);
    tick(2);
    chk("post_rst_evt", {evt_valid, evt_ch, evt_rise}, {1'b1, 2'd0, 1'b1});
    tick(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_busy", busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
